inv_key_sched: RTL and testbench

Iterative AES-128 inverse key schedule for the decryption path. Loaded with the round-10 key, it regenerates the round keys in reverse order, one per accepted transfer: K10, K9, …, K0. Each step undoes one forward key-expansion step. Keys are delivered to the inverse-cipher round datapath over a valid/ready handshake, so decryption runs without storing all 11 keys.

---
 rtl/inv_key_sched.sv | 161 ++++++++++++++++
 tb/tb_inv_key_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_sched.sv
// softbox: AES forward S-box, purely combinational byte lookup.
// Ports: in_byte -> out_byte; zero latency, no handshake.
// Backpressure: n/a.
module softbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  // Entry 0 sits in the top byte; shifting left by 8*index brings the wanted entry to the top.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [2047:0] shifted;

  always_comb begin
    shifted  = SBOX_TABLE << {in_byte, 3'b000};
    out_byte = shifted[2047:2040];
  end
endmodule

// inv_key_sched: iterative AES-128 inverse key schedule, emits K10 down to K0.
// Latency: K10 valid the cycle after an accepted start; one key per cycle at full rate.
// Backpressure: key_out/round hold while key_valid && !key_ready; done pulses after K0 transfer.
// Ports: clk, rst (sync, active high), start/lastkey load request, key_out/round/key_valid/key_ready
//        key stream, busy while sequencing, done one-cycle completion pulse.
module inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] lastkey,
  output logic [127:0] key_out,
  output logic [3:0]   round,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);
  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic         xfer;
  logic [31:0]  wa, wb, wc, wd;
  logic [31:0]  wa_p, wb_p, wc_p, wd_p;
  logic [31:0]  rot_w, sub_w;
  logic [7:0]   rc;

  // ---------------- previous-key datapath ----------------
  always_comb begin
    wa    = key_q[127:96];
    wb    = key_q[95:64];
    wc    = key_q[63:32];
    wd    = key_q[31:0];
    wd_p  = wd ^ wc;
    wc_p  = wc ^ wb;
    wb_p  = wb ^ wa;
    // RotWord of the recovered last word of the previous key, not of wd.
    rot_w = {wd_p[23:0], wd_p[31:24]};
  end

  softbox u_sbox3 (.in_byte(rot_w[31:24]), .out_byte(sub_w[31:24]));
  softbox u_sbox2 (.in_byte(rot_w[23:16]), .out_byte(sub_w[23:16]));
  softbox u_sbox1 (.in_byte(rot_w[15:8]),  .out_byte(sub_w[15:8]));
  softbox u_sbox0 (.in_byte(rot_w[7:0]),   .out_byte(sub_w[7:0]));

  // Round constant used by the forward step that produced the current key.
  always_comb begin
    rc = 8'h00;
    case (round_q)
      4'd10:   rc = 8'h36;
      4'd9:    rc = 8'h1b;
      4'd8:    rc = 8'h80;
      4'd7:    rc = 8'h40;
      4'd6:    rc = 8'h20;
      4'd5:    rc = 8'h10;
      4'd4:    rc = 8'h08;
      4'd3:    rc = 8'h04;
      4'd2:    rc = 8'h02;
      4'd1:    rc = 8'h01;
      default: rc = 8'h00;
    endcase
  end

  always_comb begin
    wa_p = wa ^ sub_w ^ {rc, 24'h000000};
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // ---------------- next-state / datapath logic ----------------
  assign xfer = (state_q == S_EMIT) && key_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EMIT;
          key_d   = lastkey;
          round_d = 4'd10;
        end
      end
      S_EMIT: begin
        // start is deliberately not looked at here: no restart while sequencing.
        if (xfer) begin
          if (round_q == 4'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = {wa_p, wb_p, wc_p, wd_p};
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    key_valid = (state_q == S_EMIT);
    busy      = (state_q == S_EMIT);
    key_out   = key_q;
    round     = round_q;
    done      = done_q;
  end
endmodule

// File: tb/tb_inv_key_sched.sv
// tb_inv_key_sched: randomized scoreboard bench for inv_key_sched.
// Expected keys come from a forward AES-128 key expansion model with an arithmetic S-box.
// A negedge monitor pops expected {round,key} on every accepted transfer.
module tb_inv_key_sched;
  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] lastkey;
  logic [127:0] key_out;
  logic [3:0]   round;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  inv_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .lastkey(lastkey),
    .key_out(key_out), .round(round), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t         exp_q[$];
  int           checks;
  int           errors;
  logic [7:0]   sbox_m [256];
  logic [127:0] rk [11];
  bit           done_pend;

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward AES-128 key expansion; rk[r] is round key r.
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcv;
    rcv = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcv, 24'h0};
        rcv = gmul(rcv, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_all();
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk[r]});
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_pend = 1'b0;
    end else begin
      chk("done_pulse", {127'h0, done}, {127'h0, done_pend});
      done_pend = 1'b0;
      if (done) chk("done_with_valid", {127'h0, key_valid}, 128'h0);
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer actual=round %0d key %h required=no transfer", round, key_out);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_round", {124'h0, round}, {124'h0, e.rnd});
          chk("xfer_key", key_out, e.key);
          if (e.rnd == 4'd0) done_pend = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus driver ----------------
  // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles at round 7.
  task automatic drive_seq(input logic [127:0] k0, input int mode, input bit fips,
                           input bit inj4, input bit injk0);
    int cyc, hold;
    bit fin, seen4;
    expand(k0);
    push_all();
    start = 1'b1;
    lastkey = rk[10];
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_valid", {127'h0, key_valid}, 128'h1);
    chk("load_round", {124'h0, round}, 128'd10);
    chk("load_key", key_out, rk[10]);
    cyc = 1; hold = 0; fin = 1'b0; seen4 = 1'b0;
    while (cyc < 400 && !fin) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        chk("busy_during_seq", {127'h0, busy}, 128'h1);
        case (mode)
          0: key_ready = 1'b1;
          1: key_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (round == 4'd7 && hold < 5) begin
              key_ready = 1'b0;
              hold++;
              chk("hold_key", key_out, rk[7]);
              chk("hold_round", {124'h0, round}, 128'd7);
            end else begin
              key_ready = 1'b1;
            end
          end
        endcase
        if (fips) begin
          case (round)
            4'd10: chk("fips_k10", key_out, FIPS_K10);
            4'd9:  chk("fips_k9", key_out, FIPS_K9);
            4'd1:  chk("fips_k1", key_out, FIPS_K1);
            4'd0:  chk("fips_k0", key_out, FIPS_K0);
            default: ;
          endcase
        end
        if (inj4 && round == 4'd4 && !seen4) begin
          start = 1'b1;
          lastkey = ~rk[10];
          seen4 = 1'b1;
        end
        if (injk0 && round == 4'd0 && key_ready) begin
          start = 1'b1;
          lastkey = ~rk[10];
        end
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL seq_timeout actual=no done after %0d cycles required=done", cyc);
    end else if (mode == 0) begin
      chk("done_cycle", 128'(cyc), 128'd12);
    end else if (mode == 2) begin
      chk("done_cycle_bp", 128'(cyc), 128'd17);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_key"}, key_out, 128'h0);
    chk({tag, "_round"}, {124'h0, round}, 128'h0);
    chk({tag, "_valid"}, {127'h0, key_valid}, 128'h0);
    chk({tag, "_busy"}, {127'h0, busy}, 128'h0);
    chk({tag, "_done"}, {127'h0, done}, 128'h0);
  endtask

  initial begin
    int guard;
    checks = 0;
    errors = 0;
    done_pend = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    key_ready = 1'b0;
    lastkey = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS vector at full rate, then back-to-back into a back-pressured run.
    drive_seq(FIPS_K0, 0, 1'b1, 1'b0, 1'b0);
    drive_seq(FIPS_K0, 2, 1'b1, 1'b0, 1'b0);
    // start while busy at round 4 must be ignored.
    drive_seq(rand128(), 1, 1'b0, 1'b1, 1'b0);
    // start in the K0 transfer cycle must be ignored.
    drive_seq(rand128(), 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("k0_start_ignored", {127'h0, key_valid}, 128'h0);

    // Reset in the middle of a sequence.
    expand(rand128());
    push_all();
    start = 1'b1;
    lastkey = rk[10];
    @(posedge clk); #1;
    start = 1'b0;
    key_ready = 1'b1;
    guard = 0;
    while (round != 4'd5 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("pre_rst_round", {124'h0, round}, 128'd5);
    rst = 1'b1;
    key_ready = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;

    // Random round-trips, chained back to back.
    for (int n = 0; n < 110; n++)
      drive_seq(rand128(), (n % 3 == 0) ? 0 : 1, 1'b0, 1'b0, 1'b0);

    key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
